// File: rtl/bit_serializer_pkg.sv
// Shared FSM package for the serializer and sequence-detector blocks.
package bit_serializer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

endpackage

// File: rtl/word_buf.sv
// One-entry word buffer: write strobe fills it, read strobe empties it.
module word_buf
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_i,
   input  logic             rd_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o
);

   logic [WIDTH-1:0] data_q;
   logic             full_q;
   logic             full_d;

   // Write wins; the parent never writes and reads in the same cycle.
   always_comb begin
      full_d = full_q;
      if (rd_i) full_d = 1'b0;
      if (wr_i) full_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         if (wr_i) data_q <= data_i;
      end
   end

   assign data_o = data_q;
   assign full_o = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word skid buffer and shift stall.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             en,
   output logic             x,
   output logic             x_valid,
   output logic             busy
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   ser_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             x_q, x_d;
   logic             xv_q, xv_d;

   logic             buf_wr;
   logic             buf_rd;
   logic             buf_full;
   logic [WIDTH-1:0] buf_data;

   logic             load_bit;
   logic [WIDTH-1:0] load_rest;
   logic             next_bit;
   logic [WIDTH-1:0] next_rest;

   assign din_ready = ~buf_full & ~rst;
   assign buf_wr    = din_valid & din_ready;

   word_buf #(
      .WIDTH (WIDTH)
   ) u_word_buf (
      .clk    (clk),
      .rst    (rst),
      .wr_i   (buf_wr),
      .rd_i   (buf_rd),
      .data_i (din),
      .data_o (buf_data),
      .full_o (buf_full)
   );

   // First bit of a freshly loaded word, and the next bit out of the shifter.
   always_comb begin
      load_bit  = buf_data[0];
      load_rest = buf_data >> 1;
      next_bit  = shift_q[0];
      next_rest = shift_q >> 1;
      if (MSB_FIRST) begin
         load_bit  = buf_data[WIDTH-1];
         load_rest = buf_data << 1;
         next_bit  = shift_q[WIDTH-1];
         next_rest = shift_q << 1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      x_d     = x_q;
      xv_d    = xv_q;
      buf_rd  = 1'b0;
      case (state_q)
         IDLE: begin
            x_d  = 1'b0;
            xv_d = 1'b0;
            if (buf_full) begin
               buf_rd  = 1'b1;
               state_d = SHIFT;
               cnt_d   = CNT_W'(WIDTH - 1);
               shift_d = load_rest;
               x_d     = load_bit;
               xv_d    = 1'b1;
            end
         end
         SHIFT: begin
            if (en) begin
               if (cnt_q != '0) begin
                  cnt_d   = cnt_q - CNT_W'(1);
                  shift_d = next_rest;
                  x_d     = next_bit;
               end else if (buf_full) begin
                  // Chain the next word on the last-bit edge to avoid a bubble.
                  buf_rd  = 1'b1;
                  cnt_d   = CNT_W'(WIDTH - 1);
                  shift_d = load_rest;
                  x_d     = load_bit;
                  xv_d    = 1'b1;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  shift_d = '0;
                  x_d     = 1'b0;
                  xv_d    = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         x_q     <= 1'b0;
         xv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         x_q     <= x_d;
         xv_q    <= xv_d;
      end
   end

   assign x       = x_q;
   assign x_valid = xv_q;
   assign busy    = (state_q == SHIFT) | buf_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_bit_serializer;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         din_valid;
   logic         en;
   logic [1:0]   din_ready_w;
   logic [1:0]   x_w;
   logic [1:0]   xv_w;
   logic [1:0]   busy_w;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_w[0]),
      .en(en), .x(x_w[0]), .x_valid(xv_w[0]), .busy(busy_w[0]));

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_w[1]),
      .en(en), .x(x_w[1]), .x_valid(xv_w[1]), .busy(busy_w[1]));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   bit started  = 1'b0;
   bit prev_rst = 1'b0;
   bit prev_en  = 1'b0;
   bit rand_mode = 1'b0;
   bit prev_xv [2];
   bit last_bit [2];
   int bit_cnt [2];
   int stall_cnt [2];
   int run_len [2];
   int last_run [2];
   int first_valid_edge [2];
   int accept_edge;
   bit q0 [$];
   bit q1 [$];

   task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst%0d: got %0h expected %0h (edge %0d)", name, k, act, exp, cyc);
      end
   endtask

   task automatic q_size(input int k, output int n);
      n = (k == 0) ? q0.size() : q1.size();
   endtask

   task automatic q_pop(input int k, output bit b);
      if (k == 0) b = q0.pop_front();
      else        b = q1.pop_front();
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Compare what the DUT shows now, given what happened at the last edge.
   task automatic mon_check(input int k);
      int n;
      bit b;
      if (prev_rst) begin
         check("post_rst_x_valid", k, xv_w[k], 0);
         check("post_rst_busy", k, busy_w[k], 0);
         check("post_rst_x", k, x_w[k], 0);
         if (!rst) check("post_rst_din_ready", k, din_ready_w[k], 1);
      end else if (xv_w[k]) begin
         check("busy_while_shifting", k, busy_w[k], 1);
         if (prev_xv[k] && !prev_en) begin
            check("stall_hold_x", k, x_w[k], last_bit[k]);
            stall_cnt[k]++;
         end else begin
            if (!prev_xv[k]) first_valid_edge[k] = cyc;
            q_size(k, n);
            if (n == 0) begin
               check("unexpected_bit_queue_level", k, 0, 1);
            end else begin
               q_pop(k, b);
               check("serial_bit", k, x_w[k], b);
               last_bit[k] = b;
               bit_cnt[k]++;
            end
         end
      end else begin
         check("idle_x_zero", k, x_w[k], 0);
         if (prev_xv[k] && !prev_en) check("stall_keeps_x_valid", k, 0, 1);
      end
      if (xv_w[k]) run_len[k]++;
      else if (run_len[k] > 0) begin
         last_run[k] = run_len[k];
         run_len[k]  = 0;
      end
   endtask

   always @(negedge clk) begin
      if (started) for (int k = 0; k < 2; k++) mon_check(k);
      if (rst) begin
         for (int k = 0; k < 2; k++) check("rst_din_ready", k, din_ready_w[k], 0);
         q0.delete();
         q1.delete();
         started = 1'b1;
      end else if (started && din_valid) begin
         if (din_ready_w[0]) begin
            for (int i = W - 1; i >= 0; i--) q0.push_back(din[i]);
            accept_edge = cyc + 1;
         end
         if (din_ready_w[1]) for (int i = 0; i < W; i++) q1.push_back(din[i]);
      end
      prev_rst = rst;
      prev_en  = en;
      for (int k = 0; k < 2; k++) prev_xv[k] = xv_w[k];
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) en = ($urandom_range(0, 3) != 0);
      if (!din_valid) din = W'($urandom);
   endtask

   task automatic send(input logic [W-1:0] w, input bit keep, output int waited);
      bit rdy;
      bit done;
      din       = w;
      din_valid = 1'b1;
      waited    = 0;
      done      = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         rdy = din_ready_w[0];
         tick();
         if (rdy) done = 1'b1;
         else     waited++;
      end
      if (!done) check("send_accept_timeout", 0, 0, 1);
      if (!keep) din_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      rand_mode = 1'b0;
      en        = 1'b1;
      din_valid = 1'b0;
      done      = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         tick();
         if (q0.size() == 0 && q1.size() == 0 && busy_w == 2'b00) done = 1'b1;
      end
      if (!done) check("drain_timeout", 0, 0, 1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w1, w2, sc, bc;
      rst = 1'b1; din = '0; din_valid = 1'b0; en = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // Single word, latency and length
      first_valid_edge[0] = -100;
      send(8'hE3, 1'b0, w1);
      drain();
      check("first_bit_edge_after_accept_edge", 0, first_valid_edge[0] - accept_edge, 1);
      check("single_run_len", 0, last_run[0], 8);
      check("single_run_len", 1, last_run[1], 8);

      // Back-to-back streaming
      send(8'hFF, 1'b1, w1);
      send(8'h00, 1'b1, w2);
      din_valid = 1'b0;
      drain();
      check("stream_run_len", 0, last_run[0], 16);
      check("stream_run_len", 1, last_run[1], 16);
      check("stream_ready_wait_le_word", 0, (w2 <= W) ? 1 : 0, 1);

      // Stall after third bit
      bc = bit_cnt[0];
      send(8'hA5, 1'b0, w1);
      repeat (3) tick();
      en = 1'b0;
      sc = stall_cnt[0];
      repeat (3) tick();
      en = 1'b1;
      tick();
      check("stall_cycles", 0, stall_cnt[0] - sc, 3);
      drain();
      check("stall_word_bits", 0, bit_cnt[0] - bc, 8);

      // Reset mid-word with a second word buffered
      bc = bit_cnt[0];
      send(8'h5A, 1'b0, w1);
      send(8'hC3, 1'b0, w2);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (20) tick();
      check("bits_before_reset", 0, bit_cnt[0] - bc, 4);
      check("idle_after_reset_busy", 0, busy_w[0], 0);
      check("idle_after_reset_busy", 1, busy_w[1], 0);

      // Buffer full must refuse a new word
      bc = bit_cnt[0];
      send(8'h3C, 1'b0, w1);
      send(8'h96, 1'b0, w2);
      din = 8'h69;
      din_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_din_ready", 0, din_ready_w[0], 0);
      end
      din_valid = 1'b0;
      drain();
      check("full_case_bits", 0, bit_cnt[0] - bc, 16);

      // LSB-first instance sees 1,1,1,0,0,0,0,0
      send(8'h07, 1'b0, w1);
      drain();

      // Randomized traffic with stalls and one reset
      rand_mode = 1'b1;
      for (int it = 0; it < 40; it++) begin
         send(W'($urandom), bit'($urandom_range(0, 1)), w1);
         if (it == 20) begin
            din_valid = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         if ($urandom_range(0, 1) == 0) din_valid = 1'b0;
         repeat ($urandom_range(0, 10)) tick();
      end
      drain();

      for (int k = 0; k < 2; k++) begin
         int n;
         q_size(k, n);
         check("final_queue_empty", k, n, 0);
         check("final_busy", k, busy_w[k], 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, 8, word width in bits (legal range 2..32).
REQ-002 SHALL have parameter: MSB_FIRST, 1, 1 = shift MSB first, 0 = shift LSB first.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port: din_valid  input  1  din holds a word to transfer.
REQ-007 SHALL have port: din_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port: en  input  1  shift enable; 0 stalls bit output.
REQ-009 SHALL have port: x  output  1  serial bit, feeding the downstream sequence detector.
REQ-010 SHALL have port: x_valid  output  1  x carries a real bit this cycle.
REQ-011 SHALL have port: busy  output  1  shifter or buffer holds data.

Function
REQ-012 SHALL transfer a word on any rising edge where din_valid=1 and din_ready=1; transfer writes din into a one-entry buffer.
REQ-013 SHALL drive din_ready = (buffer empty) and (rst=0), decoded from registers only, with no combinational path from din_valid.
REQ-014 SHALL use a two-state FSM:
  - IDLE: shifter empty.
  - SHIFT: shifter holds a word, bit counter counts WIDTH-1 down to 0.
REQ-015 SHALL, in IDLE with buffer full, move the buffer into the shifter on the next edge, enter SHIFT, and load the counter with WIDTH-1.
REQ-016 SHALL, in SHIFT with en=1, advance one bit per edge. Order: MSB first when MSB_FIRST=1, else LSB first.
REQ-017 SHALL, in SHIFT with en=0, freeze shifter, counter, x and x_valid. Buffer acceptance still proceeds.
REQ-018 SHALL register x and x_valid. x_valid=1 exactly while SHIFT presents a bit, else 0. x=0 whenever x_valid=0.
REQ-019 SHALL have latency: word accepted at edge N -> first bit on x, with x_valid=1, in the cycle after edge N+1.
REQ-020 SHALL, on the last-bit edge (counter=0, en=1), do one of:
  - buffer full: load the buffer into the shifter in the same edge, stay in SHIFT. Back-to-back words give contiguous x_valid, no bubble.
  - buffer empty: return to IDLE.
REQ-021 SHALL, when the buffer is freed and a new word arrives simultaneously, free the buffer on that edge and accept the new word one cycle later, since din_ready is registered-derived. Sustained streaming stays gapless for WIDTH>=2.
REQ-022 SHALL ignore din while din_ready=0; no word is lost or duplicated.
REQ-023 SHALL drive busy = (state=SHIFT) or (buffer full).

Reset
REQ-024 SHALL, on any edge with rst=1, force:
  - state to IDLE;
  - buffer to empty;
  - counter to 0;
  - x=0, x_valid=0, busy=0.
REQ-025 SHALL discard a partially shifted word and a buffered word on reset mid-operation; no remaining bits are emitted after rst deasserts.
REQ-026 SHALL hold din_ready=0 while rst=1, and din_ready=1 on the first cycle after rst deasserts.

Structure
REQ-027 SHALL place the state enum (IDLE, SHIFT) and the default WIDTH constant in the shared FSM package used by the sequence-detector blocks.
REQ-028 SHALL implement the one-entry buffer as sub-module word_buf (data register, full flag, write/read strobes). The FSM, counter and shifter stay in bit_serializer.

Verification
REQ-029 SHALL cover: WIDTH=8, MSB_FIRST=1, single word 8'b1110_0011, en=1 -> x = 1,1,1,0,0,0,1,1 with x_valid=1 for exactly 8 cycles, starting 2 cycles after acceptance, then IDLE.
REQ-030 SHALL cover: words 8'hFF then 8'h00, din_valid held high -> 16 contiguous x_valid cycles (eight 1s, eight 0s); din_ready never blocks longer than one word time.
REQ-031 SHALL cover: en=0 for 3 cycles after the 3rd bit of 8'hA5 -> x and x_valid frozen for 3 cycles, then the remaining bits 0,0,1,0,1 follow.
REQ-032 SHALL cover: rst=1 for one cycle after the 4th bit with a second word buffered -> next cycle x_valid=0, busy=0, din_ready=1 after release; neither word's remaining bits appear.
REQ-033 SHALL cover: buffer full and din_valid=1 with a new value -> din_ready=0, the word is not accepted, and the buffered word is emitted unchanged.
REQ-034 SHALL cover: MSB_FIRST=0, word 8'b0000_0111 -> x = 1,1,1,0,0,0,0,0.
